// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell plus a registered borrow,
// LSB first, one bit per clock, with a start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_ain,
  input  logic [WIDTH-1:0] i_bin,
  input  logic             i_bw,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_bout
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   dsh_q, dsh_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               br_q, br_d;
  logic               bout_q, bout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dbit;
  logic               bnext;
  logic               last_bit;

  function automatic logic fs_diff(input logic a, input logic b, input logic bi);
    return a ^ b ^ bi;
  endfunction

  function automatic logic fs_borrow(input logic a, input logic b, input logic bi);
    return (~a & b) | (~(a ^ b) & bi);
  endfunction

  assign dbit     = fs_diff(a_q[0], b_q[0], br_q);
  assign bnext    = fs_borrow(a_q[0], b_q[0], br_q);
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      dsh_q   <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dsh_q   <= dsh_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (i_start) state_d = S_RUN;
      S_RUN:   if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Shift datapath; the result registers load only on the MSB edge so they
  // hold the previous answer for the whole of the next operation.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    dsh_d  = dsh_q;
    diff_d = diff_q;
    br_d   = br_q;
    bout_d = bout_q;
    cnt_d  = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          a_d   = i_ain;
          b_d   = i_bin;
          br_d  = i_bw;
          cnt_d = '0;
          dsh_d = '0;
        end
      end
      S_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = bnext;
        cnt_d = cnt_q + CNT_W'(1);
        dsh_d = {dbit, dsh_q[WIDTH-1:1]};
        if (last_bit) begin
          diff_d = {dbit, dsh_q[WIDTH-1:1]};
          bout_d = bnext;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    o_busy = (state_q != S_IDLE);
    o_done = (state_q == S_DONE);
  end

  assign o_diff = diff_q;
  assign o_bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=4 and WIDTH=8: expected
// results are queued on accept and compared when o_done pulses.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start4, bw4, busy4, done4, bout4;
  logic [3:0] a4, b4, diff4;
  logic       start8, bw8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;

  int checks = 0;
  int errors = 0;
  logic [8:0] q4[$];
  logic [8:0] q8[$];
  logic [8:0] e4, e8;
  int   done_cnt4 = 0, done_cnt8 = 0;
  logic done_prev4 = 1'b0, done_prev8 = 1'b0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start4), .i_ain(a4), .i_bin(b4),
    .i_bw(bw4), .o_busy(busy4), .o_done(done4), .o_diff(diff4), .o_bout(bout4)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start8), .i_ain(a8), .i_bin(b8),
    .i_bw(bw8), .o_busy(busy8), .o_done(done8), .o_diff(diff8), .o_bout(bout8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packed {bout, diff}: the borrow-out is the sign of the 9-bit difference.
  function automatic logic [8:0] model(input int w, input logic [7:0] a,
                                       input logic [7:0] b, input logic bw);
    logic [8:0] t;
    t = {1'b0, a} - {1'b0, b} - {8'b0, bw};
    if (w == 4) return {4'b0, t[8], t[3:0]};
    return t;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (done4) begin
        done_cnt4++;
        check("done4_single", {31'b0, done_prev4}, 0);
        if (q4.size() == 0) check("done4_unexpected", 1, 0);
        else begin
          e4 = q4.pop_front();
          check("res4", {27'b0, bout4, diff4}, {23'b0, e4});
        end
      end
      if (done8) begin
        done_cnt8++;
        check("done8_single", {31'b0, done_prev8}, 0);
        if (q8.size() == 0) check("done8_unexpected", 1, 0);
        else begin
          e8 = q8.pop_front();
          check("res8", {23'b0, bout8, diff8}, {23'b0, e8});
        end
      end
    end
    done_prev4 = done4;
    done_prev8 = done8;
  end

  task automatic op(input bit w8, input logic [7:0] a, input logic [7:0] b,
                    input logic bw, input logic [8:0] exp);
    int busy_n;
    int done_at;
    logic bz, dn;
    @(posedge clk); #1;
    if (w8) begin
      start8 = 1'b1; a8 = a; b8 = b; bw8 = bw; q8.push_back(exp);
    end else begin
      start4 = 1'b1; a4 = a[3:0]; b4 = b[3:0]; bw4 = bw; q4.push_back(exp);
    end
    @(posedge clk); #1;
    start4 = 1'b0; start8 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom); bw4 = 1'($urandom);
    a8 = 8'($urandom); b8 = 8'($urandom); bw8 = 1'($urandom);
    busy_n  = 0;
    done_at = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      bz = w8 ? busy8 : busy4;
      dn = w8 ? done8 : done4;
      if (bz) busy_n++;
      if (dn && done_at < 0) done_at = n;
      if (!bz) break;
    end
    check(w8 ? "latency8" : "latency4", done_at, w8 ? 8 : 4);
    check(w8 ? "busy_len8" : "busy_len4", busy_n, w8 ? 9 : 5);
  endtask

  task automatic b2b(input bit w8, input int nops);
    int w, base;
    logic [7:0] a, b;
    logic bw;
    w    = w8 ? 8 : 4;
    base = w8 ? done_cnt8 : done_cnt4;
    @(posedge clk); #1;
    for (int i = 0; i < nops * (w + 2); i++) begin
      a  = w8 ? 8'($urandom) : {4'b0, 4'($urandom)};
      b  = w8 ? 8'($urandom) : {4'b0, 4'($urandom)};
      bw = 1'($urandom);
      if (w8) begin
        start8 = 1'b1; a8 = a; b8 = b; bw8 = bw;
        if (i % (w + 2) == 0) q8.push_back(model(8, a, b, bw));
      end else begin
        start4 = 1'b1; a4 = a[3:0]; b4 = b[3:0]; bw4 = bw;
        if (i % (w + 2) == 0) q4.push_back(model(4, a, b, bw));
      end
      @(posedge clk); #1;
    end
    start4 = 1'b0; start8 = 1'b0;
    repeat (2) @(negedge clk);
    check(w8 ? "b2b_pending8" : "b2b_pending4", w8 ? q8.size() : q4.size(), 0);
    check(w8 ? "b2b_dones8" : "b2b_dones4",
          (w8 ? done_cnt8 : done_cnt4) - base, nops);
  endtask

  initial begin
    int base, busy_seen;
    rst_n = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bw4 = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bw8 = 1'b0;
    #12;
    check("rst_busy4", busy4, 0);
    check("rst_done4", done4, 0);
    check("rst_diff4", diff4, 0);
    check("rst_bout4", bout4, 0);
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_diff8", diff8, 0);
    check("rst_bout8", bout8, 0);
    @(negedge clk); #1;
    rst_n = 1'b1;

    op(0, 8'd5,  8'd3,  1'b0, 9'h002);
    op(0, 8'd3,  8'd5,  1'b0, 9'h01E);
    op(0, 8'd0,  8'd0,  1'b1, 9'h01F);
    op(0, 8'd15, 8'd15, 1'b0, 9'h000);
    op(0, 8'd15, 8'd0,  1'b1, 9'h00E);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int bw = 0; bw < 2; bw++)
          op(0, 8'(a), 8'(b), 1'(bw), model(4, 8'(a), 8'(b), 1'(bw)));

    // Start held high with new operands through every RUN and DONE cycle.
    base = done_cnt4;
    @(posedge clk); #1;
    start4 = 1'b1; a4 = 4'd9; b4 = 4'd4; bw4 = 1'b0; q4.push_back(9'h005);
    @(posedge clk); #1;
    a4 = 4'd1; b4 = 4'd1;
    repeat (4) begin
      @(posedge clk); #1;
      a4 = 4'd1; b4 = 4'd1;
    end
    @(posedge clk); #1;
    start4 = 1'b0;
    busy_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (busy4) busy_seen++;
    end
    check("ignore_busy_after", busy_seen, 0);
    check("ignore_done_count", done_cnt4 - base, 1);

    // Asynchronous reset between E2 and E3 of a 7-2 operation.
    @(posedge clk); #1;
    start4 = 1'b1; a4 = 4'd7; b4 = 4'd2; bw4 = 1'b0; q4.push_back(9'h005);
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy4, 0);
    check("abort_done", done4, 0);
    check("abort_diff", diff4, 0);
    check("abort_bout", bout4, 0);
    q4.delete();
    q8.delete();
    base = done_cnt4;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_no_done", done_cnt4 - base, 0);
    op(0, 8'd8, 8'd1, 1'b0, 9'h007);

    b2b(0, 6);

    op(1, 8'd5,   8'd3,   1'b0, 9'h002);
    op(1, 8'd3,   8'd5,   1'b0, 9'h1FE);
    op(1, 8'd0,   8'd0,   1'b1, 9'h1FF);
    op(1, 8'd255, 8'd255, 1'b0, 9'h000);
    op(1, 8'd255, 8'd0,   1'b1, 9'h0FE);
    op(1, 8'd200, 8'd201, 1'b0, 9'h1FF);
    for (int i = 0; i < 20; i++) begin
      logic [7:0] ra, rb;
      logic rbw;
      ra = 8'($urandom); rb = 8'($urandom); rbw = 1'($urandom);
      op(1, ra, rb, rbw, model(8, ra, rb, rbw));
    end
    b2b(1, 4);

    check("final_pending4", q4.size(), 0);
    check("final_pending8", q8.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time budget");
    $fatal(1, "timeout");
  end

endmodule
